// File: rtl/csa_resolver_pkg.sv
// Shared types and elaboration helpers for the sequential carry-propagate stage.
package csa_resolver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Guarded so a bad C reaches the parameter check instead of a divide-by-zero.
  function automatic int num_chunks(input int w, input int c);
    return (c > 0) ? w / c : 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csa_chunk_add.sv
// C-bit ripple adder built from full-adder cells; purely combinational.
module csa_chunk_add #(
  parameter int C = 4
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  input  logic         ci,
  output logic [C-1:0] s,
  output logic         co
);

  logic [C:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < C; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[C];

endmodule

// File: rtl/csa_resolver.sv
// Resolves one redundant (sum, carry) pair into binary, C bits per cycle,
// with a registered carry between chunks.
module csa_resolver
  import csa_resolver_pkg::*;
#(
  parameter int W = 16,
  parameter int C = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s_vec,
  input  logic [W-1:0] c_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   result,
  output logic         busy
);

  localparam int N  = num_chunks(W, C);
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (C < 1 || W < C || (W % C) != 0) begin : g_bad_param
    $error("csa_resolver: W must be a positive multiple of C");
  end

  state_t         state, state_nx;
  logic [W-1:0]   op_s, op_c;
  logic [IW-1:0]  idx;
  logic           cy;
  logic [C-1:0]   chunk_a, chunk_b, chunk_s;
  logic           chunk_co;

  assign chunk_a = op_s[idx*C +: C];
  assign chunk_b = op_c[idx*C +: C];

  csa_chunk_add #(.C(C)) u_add (
    .a  (chunk_a),
    .b  (chunk_b),
    .ci (cy),
    .s  (chunk_s),
    .co (chunk_co)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)     state_nx = ADD;
      ADD:     if (idx == LAST)  state_nx = DONE;
      DONE:    if (out_ready)    state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_s      <= '0;
      op_c      <= '0;
      idx       <= '0;
      cy        <= 1'b0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        op_s <= s_vec;
        op_c <= c_vec;
        idx  <= '0;
        cy   <= 1'b0;
      end else if (state == ADD) begin
        // Unwritten upper chunks keep the previous result until overwritten.
        result[idx*C +: C] <= chunk_s;
        cy                 <= chunk_co;
        if (idx == LAST) begin
          idx       <= '0;
          result[W] <= chunk_co;
          out_valid <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csa_resolver.sv
// Bench for csa_resolver: C=4, C=1 and C=16 instances checked every cycle
// against a countdown model, plus directed literal scenarios on the C=4 one.
module tb_csa_resolver;

  logic        clk;
  logic        rst_n     [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [15:0] s_vec     [3];
  logic [15:0] c_vec     [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [16:0] result    [3];
  logic        busy      [3];
  logic        done      [3];
  logic        dir_done = 1'b0;
  int          checks   = 0;
  int          failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int CC = (g == 0) ? 4 : (g == 1) ? 1 : 16;
    localparam int NN = 16 / CC;

    string       tag;
    logic        m_busy = 1'b0;
    logic        m_val  = 1'b0;
    int          m_cnt  = 0;
    logic [16:0] m_res  = '0;
    int          n_done = 0;

    csa_resolver #(.W(16), .C(CC)) dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .s_vec     (s_vec[g]),
      .c_vec     (c_vec[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .result    (result[g]),
      .busy      (busy[g])
    );

    // Inputs change at negedge+2, so values seen here are those of the last posedge.
    always @(negedge clk) begin
      if (!rst_n[g]) begin
        m_busy = 1'b0;
        m_val  = 1'b0;
        m_cnt  = 0;
        chk({tag, "_rst_result"}, result[g], 0);
      end else if (!m_busy) begin
        if (in_valid[g]) begin
          m_busy = 1'b1;
          m_cnt  = NN;
          m_res  = {1'b0, s_vec[g]} + {1'b0, c_vec[g]};
        end
      end else if (!m_val) begin
        m_cnt--;
        if (m_cnt == 0) m_val = 1'b1;
      end else if (out_ready[g]) begin
        m_busy = 1'b0;
        m_val  = 1'b0;
        n_done++;
      end
      chk({tag, "_in_ready"},  in_ready[g],  !m_busy);
      chk({tag, "_busy"},      busy[g],      m_busy);
      chk({tag, "_out_valid"}, out_valid[g], m_val);
      if (m_val) chk({tag, "_result"}, result[g], m_res);
    end

    initial begin
      int budget;
      int target;
      tag         = $sformatf("c%0d", CC);
      rst_n[g]    = 1'b0;
      in_valid[g] = 1'b0;
      out_ready[g]= 1'b0;
      s_vec[g]    = '0;
      c_vec[g]    = '0;
      done[g]     = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n[g] = 1'b1;
      wait (dir_done === 1'b1);
      target = (CC == 4) ? 300 : 1000;
      budget = 0;
      while (n_done < target && budget < 40000) begin
        in_valid[g]  = ($urandom_range(0, 7) != 0);
        out_ready[g] = ($urandom_range(0, 3) != 0);
        s_vec[g]     = 16'($urandom);
        c_vec[g]     = 16'($urandom);
        @(negedge clk);
        #2 budget++;
      end
      chk({tag, "_random_done"}, (n_done >= target), 1);
      done[g] = 1'b1;
    end
  end

  task automatic basic(input logic [15:0] s, input logic [15:0] c,
                       input logic [16:0] e, input string nm);
    int first;
    int lows;
    first = 0;
    lows  = 0;
    s_vec[0]     = s;
    c_vec[0]     = c;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (!in_ready[0]) lows++;
      if (out_valid[0] && first == 0) begin
        first = k;
        chk({nm, "_result"}, result[0], e);
      end
      #2 in_valid[0] = 1'b0;
    end
    chk({nm, "_latency"}, first - 1, 4);
    chk({nm, "_ready_low"}, lows, 5);
  endtask

  initial begin : directed
    int n;
    int last;
    int cyc;
    #3;
    chk("reset_result",    result[0],    0);
    chk("reset_out_valid", out_valid[0], 0);
    chk("reset_in_ready",  in_ready[0],  1);
    chk("reset_busy",      busy[0],      0);
    wait (rst_n[0] === 1'b1);
    @(negedge clk);
    #2;

    basic(16'h1234, 16'h4321, 17'h05555, "basic");
    basic(16'hFFFF, 16'h0001, 17'h10000, "ripple_one");
    basic(16'hFFFF, 16'hFFFF, 17'h1FFFE, "ripple_all");

    // Backpressure: stall 10 cycles with a second pair already waiting.
    s_vec[0]     = 16'h00FF;
    c_vec[0]     = 16'h0F01;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k >= 5 && k <= 14) begin
        chk("bp_out_valid", out_valid[0], 1);
        chk("bp_result",    result[0],    17'h01000);
        chk("bp_in_ready",  in_ready[0],  0);
      end
      if (k == 15) begin
        chk("bp_idle_after_hs", in_ready[0],  1);
        chk("bp_valid_dropped", out_valid[0], 0);
      end
      if (k == 16) chk("bp_second_accept", in_ready[0], 0);
      if (k == 20) begin
        chk("bp_second_valid",  out_valid[0], 1);
        chk("bp_second_result", result[0],    17'h00003);
      end
      #2;
      if (k == 1) begin
        s_vec[0] = 16'h0001;
        c_vec[0] = 16'h0002;
      end
      if (k == 14) out_ready[0] = 1'b1;
      if (k == 16) in_valid[0]  = 1'b0;
    end

    // Reset during the second ADD cycle.
    s_vec[0]     = 16'h1234;
    c_vec[0]     = 16'h1111;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    #2 in_valid[0] = 1'b0;
    @(negedge clk);
    #2 rst_n[0] = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid[0], 0);
    chk("midrst_result",    result[0],    0);
    chk("midrst_in_ready",  in_ready[0],  1);
    chk("midrst_busy",      busy[0],      0);
    @(negedge clk);
    #2 rst_n[0] = 1'b1;
    basic(16'h0F0F, 16'hF0F0, 17'h0FFFF, "post_rst");

    // Back-to-back with both handshakes held high.
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    n    = 0;
    last = 0;
    cyc  = 0;
    while (n < 8 && cyc < 100) begin
      s_vec[0] = 16'($urandom);
      c_vec[0] = 16'($urandom);
      @(negedge clk);
      cyc++;
      if (out_valid[0]) begin
        if (n > 0) chk("b2b_spacing", cyc - last, 6);
        last = cyc;
        n++;
      end
      #2;
    end
    in_valid[0] = 1'b0;
    chk("b2b_count", n, 8);
    @(negedge clk);
    #2 dir_done = 1'b1;
  end

  initial begin
    wait (done[0] === 1'b1 && done[1] === 1'b1 && done[2] === 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=all_done");
    $fatal(1, "watchdog expired");
  end

endmodule
